// File: rtl/cdc_pkg.sv
// Shared CDC byte-path definitions used by the synchronizer, its upstream source
// and the destination-side word packer.
package cdc_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic                     full_o,
  input  logic                     pop_i,
  output logic                     empty_o,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_pop   = pop_i && !w_empty;
  assign w_push  = push_i && (!w_full || w_pop);

  // Storage and pointers; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din_i;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (w_pop && !w_push) r_level <= r_level - LW'(1);
    end
  end

  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign dout_o  = r_mem[r_rd_ptr];
  assign level_o = r_level;

endmodule

// File: rtl/cdc_rx_word_packer.sv
// Packs synchronized byte strobes little-endian into NB-byte words, buffers them
// in a FWFT FIFO for a valid/ready consumer, and tracks dropped words on overflow.
module cdc_rx_word_packer
  import cdc_pkg::*;
#(
  parameter int unsigned NB    = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_pulse,
  input  byte_t                   din,
  input  logic                    flush_i,
  input  logic                    ovf_clr_i,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [BYTE_W*NB-1:0]    m_data,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    ovf_o,
  output logic [7:0]              drop_cnt
);

  localparam int unsigned WORD_W = BYTE_W * NB;
  localparam int unsigned CW     = $clog2(NB);

  logic [CW-1:0]              r_cnt;
  logic [NB-1:0][BYTE_W-1:0]  r_asm;
  logic                       r_ovf;
  logic [7:0]                 r_drop_cnt;

  logic [NB-1:0][BYTE_W-1:0]  w_word;
  logic                       w_last;
  logic                       w_complete;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_pop;
  logic                       w_drop;

  assign w_last     = (r_cnt == CW'(NB - 1));
  assign w_complete = in_pulse && !flush_i && w_last;
  assign w_pop      = !w_empty && m_ready;
  assign w_drop     = w_complete && w_full && !w_pop;

  // Completed word takes the live byte in the top lane, earlier lanes from the register.
  always_comb begin
    w_word         = r_asm;
    w_word[NB-1]   = din;
  end

  // Lane counter and assembly register; flush discards the byte on the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_asm <= '0;
    end else if (flush_i) begin
      r_cnt <= '0;
    end else if (in_pulse) begin
      r_asm[r_cnt] <= din;
      r_cnt        <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

  // Sticky overflow (set beats clear) and saturating drop counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_drop)         r_ovf <= 1'b1;
      else if (ovf_clr_i) r_ovf <= 1'b0;
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_complete),
    .din_i   (WORD_W'(w_word)),
    .full_o  (w_full),
    .pop_i   (m_ready),
    .empty_o (w_empty),
    .dout_o  (m_data),
    .level_o (level_o)
  );

  assign m_valid  = !w_empty;
  assign ovf_o    = r_ovf;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_cdc_rx_word_packer.sv
// Self-checking bench for cdc_rx_word_packer: directed vector table, corner-case
// sequences and a randomized run against a queue-based reference model.
module tb_cdc_rx_word_packer;

  localparam int unsigned NB     = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned WORD_W = 8 * NB;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic                    in_pulse;
  logic [7:0]              din;
  logic                    flush_i;
  logic                    ovf_clr_i;
  logic                    m_valid;
  logic                    m_ready;
  logic [WORD_W-1:0]       m_data;
  logic [$clog2(DEPTH):0]  level_o;
  logic                    ovf_o;
  logic [7:0]              drop_cnt;

  cdc_rx_word_packer #(.NB(NB), .DEPTH(DEPTH)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_pulse  (in_pulse),
    .din       (din),
    .flush_i   (flush_i),
    .ovf_clr_i (ovf_clr_i),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .level_o   (level_o),
    .ovf_o     (ovf_o),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: FIFO as a queue of words, partial word as a list of bytes.
  logic [WORD_W-1:0] mq[$];
  logic [7:0]        part[$];
  bit                m_ovf;
  int                m_drop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("model m_valid", 64'(m_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) chk("model m_data", 64'(m_data), 64'(mq[0]));
    chk("model level_o", 64'(level_o), 64'(mq.size()));
    chk("model ovf_o", 64'(ovf_o), 64'(m_ovf));
    chk("model drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic model_step(input bit p, input logic [7:0] d, input bit f,
                            input bit r, input bit c, input bit rs);
    int sz;
    bit pop;
    bit drop;
    logic [WORD_W-1:0] w;
    if (rs) begin
      mq.delete();
      part.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
      return;
    end
    sz   = mq.size();
    pop  = (sz > 0) && r;
    drop = 1'b0;
    if (pop) w = mq.pop_front();
    if (f) begin
      part.delete();
    end else if (p) begin
      part.push_back(d);
      if (part.size() == NB) begin
        w = '0;
        for (int k = 0; k < int'(NB); k++) w = w | (WORD_W'(part[k]) << (8 * k));
        if (sz < int'(DEPTH) || pop) mq.push_back(w);
        else drop = 1'b1;
        part.delete();
      end
    end
    if (drop) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end else if (c) begin
      m_ovf = 1'b0;
    end
  endtask

  // One clock: drive inputs, compare against the model, take the edge, sample after.
  task automatic cyc(input bit p, input logic [7:0] d, input bit f,
                     input bit r, input bit c, input bit rs);
    in_pulse  = p;
    din       = d;
    flush_i   = f;
    m_ready   = r;
    ovf_clr_i = c;
    rst_i     = rs;
    model_check();
    @(posedge clk_i);
    model_step(p, d, f, r, c, rs);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit r);
    cyc(1'b1, d, 1'b0, r, 1'b0, 1'b0);
  endtask

  task automatic idle(input bit r);
    cyc(1'b0, 8'h00, 1'b0, r, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit          p;
    logic [7:0]  d;
    bit          f;
    bit          r;
    bit          ev;
    logic [31:0] ed;
    logic [2:0]  el;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int vcount;
    logic [31:0] exp_w;

    // Flush mid-word, then a flush landing on the completing byte.
    tbl[0]  = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0};
    tbl[1]  = '{1'b1, 8'h0B, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};
    tbl[3]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0};
    tbl[4]  = '{1'b1, 8'h08, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0};
    tbl[5]  = '{1'b1, 8'h0E, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0};
    tbl[6]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 32'h010E0804, 3'd1};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0};
    tbl[8]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0};
    tbl[9]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0};
    tbl[10] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0};
    tbl[11] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};
    tbl[12] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0};
    tbl[13] = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0};
    tbl[14] = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0};
    tbl[15] = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 32'hA4A3A2A1, 3'd1};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0};

    in_pulse = 0; din = 0; flush_i = 0; ovf_clr_i = 0; m_ready = 0; rst_i = 1;
    @(posedge clk_i);
    model_step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("reset m_valid", 64'(m_valid), 64'd0);
    chk("reset level_o", 64'(level_o), 64'd0);
    chk("reset ovf_o", 64'(ovf_o), 64'd0);
    chk("reset drop_cnt", 64'(drop_cnt), 64'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Test 1: spaced bytes, single word visible for exactly one cycle.
    vcount = 0;
    send_byte(8'h05, 1'b1);
    for (int i = 0; i < 9; i++) idle(1'b1);
    send_byte(8'h0B, 1'b1);
    for (int i = 0; i < 9; i++) idle(1'b1);
    send_byte(8'h04, 1'b1);
    for (int i = 0; i < 9; i++) idle(1'b1);
    chk("t1 no early valid", 64'(m_valid), 64'd0);
    send_byte(8'h08, 1'b1);
    chk("t1 valid after last byte", 64'(m_valid), 64'd1);
    chk("t1 word", 64'(m_data), 64'h08040B05);
    if (m_valid) vcount++;
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      if (m_valid) vcount++;
    end
    chk("t1 valid cycles", 64'(vcount), 64'd1);
    chk("t1 level back to 0", 64'(level_o), 64'd0);

    // Test 2: vector table.
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].p, tbl[i].d, tbl[i].f, tbl[i].r, 1'b0, 1'b0);
      chk($sformatf("tbl[%0d] valid", i), 64'(m_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("tbl[%0d] data", i), 64'(m_data), 64'(tbl[i].ed));
      chk($sformatf("tbl[%0d] level", i), 64'(level_o), 64'(tbl[i].el));
    end
    chk("t2 no drop from flush", 64'(drop_cnt), 64'd0);

    // Test 3: five words into a stalled FIFO; fifth is dropped.
    for (int i = 0; i < 20; i++) send_byte(8'(i + 1), 1'b0);
    chk("t3 level full", 64'(level_o), 64'd4);
    chk("t3 ovf set", 64'(ovf_o), 64'd1);
    chk("t3 drop_cnt", 64'(drop_cnt), 64'd1);
    for (int w = 0; w < 4; w++) begin
      exp_w = '0;
      for (int k = 0; k < 4; k++) exp_w = exp_w | (32'(4 * w + k + 1) << (8 * k));
      chk($sformatf("t3 drain valid %0d", w), 64'(m_valid), 64'd1);
      chk($sformatf("t3 drain word %0d", w), 64'(m_data), 64'(exp_w));
      idle(1'b1);
    end
    chk("t3 fifth absent", 64'(m_valid), 64'd0);

    // Test 4: push onto a full FIFO with a simultaneous pop is not a drop.
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4 ovf cleared", 64'(ovf_o), 64'd0);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i), 1'b0);
    chk("t4 full", 64'(level_o), 64'd4);
    for (int i = 0; i < 3; i++) send_byte(8'(8'h60 + i), 1'b0);
    send_byte(8'h63, 1'b1);
    chk("t4 level stays", 64'(level_o), 64'd4);
    chk("t4 no ovf", 64'(ovf_o), 64'd0);
    chk("t4 drop unchanged", 64'(drop_cnt), 64'd1);
    chk("t4 head advanced", 64'(m_data), 64'h47464544);

    // Test 5: clear coinciding with a drop loses to the set.
    for (int i = 0; i < 4; i++) send_byte(8'(8'h70 + i), 1'b0);
    chk("t5 drop", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < 3; i++) send_byte(8'(8'h80 + i), 1'b0);
    cyc(1'b1, 8'h83, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5 set beats clear", 64'(ovf_o), 64'd1);
    chk("t5 drop incremented", 64'(drop_cnt), 64'd3);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5 clear alone", 64'(ovf_o), 64'd0);
    chk("t5 drop kept", 64'(drop_cnt), 64'd3);

    // Test 6: reset mid-word with words queued, overriding a concurrent byte.
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h90 + i), 1'b0);
    chk("t6 queued", 64'(level_o), 64'd2);
    cyc(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t6 valid cleared", 64'(m_valid), 64'd0);
    chk("t6 level cleared", 64'(level_o), 64'd0);
    for (int i = 0; i < 4; i++) send_byte(8'(8'hC1 + i), 1'b0);
    chk("t6 fresh word valid", 64'(m_valid), 64'd1);
    chk("t6 fresh word", 64'(m_data), 64'hC4C3C2C1);

    // Drop counter saturation.
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4 * 264; i++) send_byte(8'(i), 1'b0);
    chk("sat drop_cnt", 64'(drop_cnt), 64'd255);
    chk("sat level", 64'(level_o), 64'd4);
    chk("sat ovf", 64'(ovf_o), 64'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 299) == 0));
    end
    model_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
